// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative radix-2 shift-add multiply / restoring divide sharing one adder.
// Optional MULT_DIV_EARLY_TERM_EN: multiply leaves ITER once the remaining multiplier bits are zero.
module mult_div_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  mult_start,
    input  logic                  div_start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] Op_A,
    input  logic [DATA_WIDTH-1:0] Op_B,
    output logic                  busy,
    output logic                  mult_div_done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int DW = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DW - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state, state_nx;
    logic start, is_div, sign_q, sign_r, dz, last, skip;
    logic [CNT_WIDTH-1:0] count;
    logic [DW-1:0] acc, mq, md, mag_a, mag_b, raw_a, div_q, div_r;
    logic [DW:0] sh, op_x, op_y, sum;
    logic [2*DW-1:0] prod, prod_fix;

    assign start = mult_start | div_start;
    assign mag_a = (signed_op && Op_A[DW-1]) ? -Op_A : Op_A;
    assign mag_b = (signed_op && Op_B[DW-1]) ? -Op_B : Op_B;

    // acc is the product high half / partial remainder; mq the multiplier / quotient
    assign sh   = {acc, mq[DW-1]};
    assign op_x = is_div ? sh : {1'b0, acc};
    assign op_y = is_div ? ~{1'b0, md} : {1'b0, mq[0] ? md : {DW{1'b0}}};
    assign sum  = op_x + op_y + {{DW{1'b0}}, is_div};

    // sign_r is only set in signed mode, so negating the stored magnitude recovers the raw dividend
    assign raw_a    = sign_r ? -mq : mq;
    assign div_q    = sign_q ? -mq : mq;
    assign div_r    = sign_r ? -acc : acc;
    assign prod_fix = sign_q ? -prod : prod;

`ifdef MULT_DIV_EARLY_TERM_EN
    logic [DW-1:0] mb;
    assign last = count == LAST || (!is_div && (mb >> 1) == '0);
    assign skip = is_div ? md == '0 : mq == '0;
    assign prod = {acc, mq} >> (CNT_WIDTH'(DW) - count);
`else
    assign last = count == LAST;
    assign skip = is_div && md == '0;
    assign prod = {acc, mq};
`endif

    assign busy          = state != IDLE;
    assign mult_div_done = state == DONE;
    assign div_by_zero   = state == DONE && dz;

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state sequencing
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = skip ? FIX : ITER;
            ITER:    state_nx = last ? FIX : ITER;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, iteration datapath and result load
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc    <= '0;
            mq     <= '0;
            md     <= '0;
            count  <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
`ifdef MULT_DIV_EARLY_TERM_EN
            mb     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    is_div <= !mult_start;
                    md     <= mult_start ? mag_a : mag_b;
                    mq     <= mult_start ? mag_b : mag_a;
                    sign_q <= signed_op & (Op_A[DW-1] ^ Op_B[DW-1]);
                    sign_r <= signed_op & Op_A[DW-1];
`ifdef MULT_DIV_EARLY_TERM_EN
                    mb     <= mag_b;
`endif
                end
                PREP: begin
                    acc   <= '0;
                    count <= '0;
                    dz    <= is_div && md == '0;
                end
                ITER: begin
                    count <= count + 1'b1;
                    acc   <= is_div ? (sum[DW] ? sh[DW-1:0] : sum[DW-1:0]) : sum[DW:1];
                    mq    <= is_div ? {mq[DW-2:0], !sum[DW]} : {sum[0], mq[DW-1:1]};
`ifdef MULT_DIV_EARLY_TERM_EN
                    mb    <= mb >> 1;
`endif
                end
                FIX: {hi_out, lo_out} <= dz ? {raw_a, {DW{1'b1}}} : is_div ? {div_r, div_q} : prod_fix;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed and randomized checks of mult_div_sequencer against an arithmetic model.
module tb_mult_div_sequencer;
    logic CLK = 1'b0;
    logic RST, mult_start, div_start, signed_op;
    logic [31:0] Op_A, Op_B;
    logic busy, mult_div_done, div_by_zero;
    logic [31:0] hi_out, lo_out;
    int checks = 0;
    int failures = 0;

`ifdef MULT_DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mult_div_sequencer dut (
        .CLK(CLK), .RST(RST), .mult_start(mult_start), .div_start(div_start),
        .signed_op(signed_op), .Op_A(Op_A), .Op_B(Op_B), .busy(busy),
        .mult_div_done(mult_div_done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 CLK = ~CLK;

    // {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (m) begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            return {32'b0, a} * {32'b0, b};
        end
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // cycles from the start-request cycle to the done cycle
    function automatic int exp_lat(input logic m, input logic s, input logic [31:0] b);
        logic [31:0] mag;
        int n;
        mag = (s && b[31]) ? -b : b;
        n = 0;
        while (mag != 0) begin
            mag = mag >> 1;
            n++;
        end
        if (!m) return (b == 0) ? 3 : 35;
        return EARLY ? 3 + n : 35;
    endfunction

    // issue one request, observe a fixed 60-cycle window; optional extra start at cycle inj
    task automatic do_op(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output int nbusy, output int ndone,
                         output logic pre_busy, output logic dzo, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge CLK);
        mult_start = m; div_start = d; signed_op = s; Op_A = a; Op_B = b;
        pre_busy = busy;
        @(posedge CLK);
        #1;
        mult_start = 0; div_start = 0;
        signed_op = 1'($urandom); Op_A = $urandom; Op_B = $urandom;
        lat = -1; nbusy = 0; ndone = 0; dzo = 0; hi = 0; lo = 0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if (busy) nbusy++;
            if (mult_div_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c + 1; dzo = div_by_zero; hi = hi_out; lo = lo_out;
                end
            end
            mult_start = (c == inj);
            div_start  = (c == inj);
        end
        mult_start = 0; div_start = 0;
    endtask

    task automatic test_reset();
        RST = 1; mult_start = 0; div_start = 0; signed_op = 0; Op_A = 0; Op_B = 0;
        repeat (3) @(posedge CLK);
        #1;
        checks += 5;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (mult_div_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", mult_div_done); end
        if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
        if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
        if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
        RST = 0;
    endtask

    typedef struct packed {
        logic m, d, s;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic test_directed();
        vec_t v [9];
        int lat, nb, nd, el;
        logic pb, dzo, edz;
        logic [31:0] hi, lo;
        v = '{
            '{1'b1, 1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
            '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE},
            '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE},
            '{1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{1'b0, 1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14},
            '{1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
            '{1'b0, 1'b1, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF},
            '{1'b1, 1'b1, 1'b0, 32'd6,        32'd4,        32'd0,        32'd24},
            '{1'b1, 1'b0, 1'b0, 32'd5,        32'd1,        32'd0,        32'd5}
        };
        foreach (v[i]) begin
            do_op(v[i].m, v[i].d, v[i].s, v[i].a, v[i].b, -1, lat, nb, nd, pb, dzo, hi, lo);
            el  = exp_lat(v[i].m, v[i].s, v[i].b);
            edz = !v[i].m && v[i].b == 0;
            checks += 7;
            if (hi !== v[i].hi) begin failures++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, v[i].hi); end
            if (lo !== v[i].lo) begin failures++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, v[i].lo); end
            if (lat != el) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el); end
            if (nb != el) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, nb, el); end
            if (nd != 1) begin failures++; $display("FAIL dir%0d_done_pulses: got %0d expected 1", i, nd); end
            if (pb !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_in_idle: got %b expected 0", i, pb); end
            if (dzo !== edz) begin failures++; $display("FAIL dir%0d_dz: got %b expected %b", i, dzo, edz); end
        end
    endtask

    task automatic test_ignore_mid();
        int lat, nb, nd;
        logic pb, dzo;
        logic [31:0] a, b, hi, lo;
        logic [63:0] e;
        a = $urandom; b = $urandom | 32'h40000000;
        e = model(1'b1, 1'b1, a, b);
        do_op(1'b1, 1'b0, 1'b1, a, b, 10, lat, nb, nd, pb, dzo, hi, lo);
        checks += 3;
        if ({hi, lo} !== e) begin failures++; $display("FAIL mid_start_result: got %h expected %h", {hi, lo}, e); end
        if (nd != 1) begin failures++; $display("FAIL mid_start_done_pulses: got %0d expected 1", nd); end
        if (nb != exp_lat(1'b1, 1'b1, b)) begin failures++; $display("FAIL mid_start_busy_cycles: got %0d expected %0d", nb, exp_lat(1'b1, 1'b1, b)); end
    endtask

    task automatic test_reset_abort();
        int nd, lat, nb;
        logic pb, dzo;
        logic [31:0] hi, lo;
        logic [63:0] e;
        @(negedge CLK);
        mult_start = 1; signed_op = 0; Op_A = 32'hDEADBEEF; Op_B = 32'hFFFFFFFF;
        @(posedge CLK);
        #1;
        mult_start = 0;
        repeat (11) @(posedge CLK);
        #1;
        RST = 1;
        @(posedge CLK);
        #1;
        RST = 0;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (hi_out !== 32'h0) begin failures++; $display("FAIL abort_hi: got %h expected 0", hi_out); end
        if (lo_out !== 32'h0) begin failures++; $display("FAIL abort_lo: got %h expected 0", lo_out); end
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge CLK);
            #1;
            if (mult_div_done) nd++;
        end
        checks++;
        if (nd != 0) begin failures++; $display("FAIL abort_done_pulses: got %0d expected 0", nd); end
        e = model(1'b0, 1'b1, 32'hFFFFFF9C, 32'd9);
        do_op(1'b0, 1'b1, 1'b1, 32'hFFFFFF9C, 32'd9, -1, lat, nb, nd, pb, dzo, hi, lo);
        checks += 2;
        if ({hi, lo} !== e) begin failures++; $display("FAIL after_abort_result: got %h expected %h", {hi, lo}, e); end
        if (lat != 35) begin failures++; $display("FAIL after_abort_latency: got %0d expected 35", lat); end
    endtask

    task automatic test_random();
        int lat, nb, nd, el;
        logic pb, dzo, m, s;
        logic [31:0] a, b, hi, lo;
        logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom); s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0: b = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFFFFFF;
                1: b = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            e  = model(m, s, a, b);
            el = exp_lat(m, s, b);
            do_op(m, !m, s, a, b, -1, lat, nb, nd, pb, dzo, hi, lo);
            checks += 5;
            if ({hi, lo} !== e) begin failures++; $display("FAIL rnd%0d_result m=%b s=%b a=%h b=%h: got %h expected %h", i, m, s, a, b, {hi, lo}, e); end
            if (lat != el) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el); end
            if (nd != 1) begin failures++; $display("FAIL rnd%0d_done_pulses: got %0d expected 1", i, nd); end
            if (dzo !== (!m && b == 0)) begin failures++; $display("FAIL rnd%0d_dz: got %b expected %b", i, dzo, !m && b == 0); end
            if ({hi_out, lo_out} !== e) begin failures++; $display("FAIL rnd%0d_hold: got %h expected %h", i, {hi_out, lo_out}, e); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_mid();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
